// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use, load scoreboard RAW/WAW, load capacity, branch flush.
// Optional macro HAZARD_PERF_CNT_EN adds the o_stall_cycles counter.
module hazard_unit #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_r_we,
  input  logic             i_id_mem_read,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req_fire,
  input  logic [4:0]       i_mem_req_rd,
  input  logic             i_wb_load_valid,
  input  logic [4:0]       i_wb_load_rd,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic [CNT_W-1:0] o_outstanding,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      o_stall_cycles,
`endif
  output logic             o_err
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      r_pending;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [31:0]      w_clr_mask;
  logic [31:0]      w_set_mask;
  logic [31:0]      w_pend_eff;
  logic             w_load_use;
  logic             w_sb_raw;
  logic             w_waw;
  logic             w_capacity;
  logic             w_stall;
  logic             w_flush;
  logic [CNT_W-1:0] w_count_next;
  logic             w_err_next;

  // One-hot clear/set masks; x0 can never become pending.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mask
      assign w_clr_mask[gi] = i_wb_load_valid && (i_wb_load_rd == 5'(gi));
      if (gi == 0) begin : g_x0
        assign w_set_mask[gi] = 1'b0;
      end else begin : g_xn
        assign w_set_mask[gi] = i_mem_req_fire && (i_mem_req_rd == 5'(gi));
      end
    end
  endgenerate

  // Write-through register file: a bit retiring this cycle no longer blocks.
  assign w_pend_eff = r_pending & ~w_clr_mask;

  assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                      ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));
  assign w_sb_raw   = (i_id_rs1_used && w_pend_eff[i_id_rs1]) ||
                      (i_id_rs2_used && w_pend_eff[i_id_rs2]);
  assign w_waw      = i_id_r_we && (i_id_rd != 5'd0) && w_pend_eff[i_id_rd];
  assign w_capacity = i_id_mem_read && (r_count == LP_MAX) && !i_wb_load_valid;

  assign w_flush = i_rst_n && i_ex_branch_taken;
  assign w_stall = i_rst_n && !i_ex_branch_taken &&
                   (w_load_use || w_sb_raw || w_waw || w_capacity);

  assign o_stall_if    = w_stall;
  assign o_stall_id    = w_stall;
  assign o_bubble_ex   = w_stall;
  assign o_flush_if_id = w_flush;
  assign o_flush_id_ex = w_flush;
  assign o_outstanding = r_count;
  assign o_err         = r_err;

  always_comb begin
    w_count_next = r_count;
    w_err_next   = r_err;
    if (i_mem_req_fire && !i_wb_load_valid) begin
      if (r_count == LP_MAX) w_err_next = 1'b1;
      else                   w_count_next = r_count + CNT_W'(1);
    end else if (i_wb_load_valid && !i_mem_req_fire) begin
      if (r_count == '0) w_err_next = 1'b1;
      else               w_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      // Set is applied after clear so a same-cycle reissue stays pending.
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'h1;
      r_count   <= w_count_next;
      r_err     <= w_err_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_stall_cycles <= '0;
    else if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MAX_OUTSTANDING = 2).
module tb_hazard_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, req_rd, wb_rd;
  logic       rs1_used, rs2_used, id_we, id_mrd, ex_mrd, br;
  logic       req_fire, wb_valid;
  logic       stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, err;
  logic [1:0] outstanding;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MAX_OUTSTANDING(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd(id_rd), .i_id_r_we(id_we), .i_id_mem_read(id_mrd),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mrd), .i_ex_branch_taken(br),
    .i_mem_req_fire(req_fire), .i_mem_req_rd(req_rd),
    .i_wb_load_valid(wb_valid), .i_wb_load_rd(wb_rd),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_bubble_ex(bubble_ex),
    .o_flush_if_id(flush_if_id), .o_flush_id_ex(flush_id_ex),
    .o_outstanding(outstanding),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_cycles(stall_cycles),
`endif
    .o_err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex}.
  function automatic logic [31:0] ctl();
    return {27'd0, stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex};
  endfunction

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rd = 0; req_rd = 0; wb_rd = 0;
    rs1_used = 0; rs2_used = 0; id_we = 0; id_mrd = 0; ex_mrd = 0; br = 0;
    req_fire = 0; wb_valid = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] STALL = 32'b11100;
  localparam logic [31:0] FLUSH = 32'b00011;
  localparam logic [31:0] IDLE  = 32'b00000;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Hazard and flush inputs active during reset: everything must read 0.
    ex_mrd = 1; ex_rd = 5; id_rs1 = 5; rs1_used = 1; br = 1;
    #1;
    check("reset_ctl", ctl(), IDLE);
    check("reset_outstanding", 32'(outstanding), 0);
    check("reset_err", 32'(err), 0);
    step();
    rst_n = 1'b1;
    br = 0;
    #1;
    check("load_use_stall", ctl(), STALL);
    rs1_used = 0; #1;
    check("load_use_rs_unused", ctl(), IDLE);
    rs1_used = 1; ex_rd = 0; id_rs1 = 0; #1;
    check("load_use_x0", ctl(), IDLE);
    clear_inputs();

    // Scoreboard RAW on x7
    req_fire = 1; req_rd = 7;
    step();
    req_fire = 0; id_rs2 = 7; rs2_used = 1; #1;
    check("sb_outstanding_1", 32'(outstanding), 1);
    check("sb_raw_stall", ctl(), STALL);
    step();
    check("sb_raw_held", ctl(), STALL);
    wb_valid = 1; wb_rd = 7; #1;
    check("sb_raw_wb_bypass", ctl(), IDLE);
    step();
    wb_valid = 0; #1;
    check("sb_cleared", ctl(), IDLE);
    check("sb_outstanding_0", 32'(outstanding), 0);
    clear_inputs();

    // Capacity with MAX_OUTSTANDING = 2
    req_fire = 1; req_rd = 3; step();
    req_rd = 4; step();
    req_fire = 0; id_mrd = 1; #1;
    check("cap_outstanding_2", 32'(outstanding), 2);
    check("cap_stall", ctl(), STALL);
    wb_valid = 1; wb_rd = 10; #1;
    check("cap_wb_relief", ctl(), IDLE);
    wb_valid = 0; id_mrd = 0; id_we = 1; id_rd = 3; #1;
    check("waw_pending_load", ctl(), STALL);
    id_we = 0;
    req_fire = 1; req_rd = 0; step();
    req_fire = 0; #1;
    check("overflow_err", 32'(err), 1);
    check("overflow_saturate", 32'(outstanding), 2);

    // Flush overrides an active stall
    id_rs1 = 3; rs1_used = 1; #1;
    check("pre_flush_stall", ctl(), STALL);
    br = 1; #1;
    check("flush_priority", ctl(), FLUSH);
    clear_inputs();

    // Drain; error stays sticky
    wb_valid = 1; wb_rd = 3; step();
    wb_rd = 4; step();
    wb_valid = 0; #1;
    check("drain_outstanding", 32'(outstanding), 0);
    check("err_sticky", 32'(err), 1);

    // Same-cycle set and clear of x9: set wins, count unchanged
    req_fire = 1; req_rd = 11; step();
    req_rd = 9; wb_valid = 1; wb_rd = 9; step();
    req_fire = 0; wb_valid = 0; #1;
    check("setclr_outstanding", 32'(outstanding), 1);
    id_we = 1; id_rd = 9; #1;
    check("setclr_waw", ctl(), STALL);
    wb_valid = 1; #1;
    check("waw_clear_bypass", ctl(), IDLE);
    wb_valid = 0; id_rd = 0; #1;
    check("waw_x0", ctl(), IDLE);
    id_rd = 9; #1;
    check("waw_again", ctl(), STALL);

    // Asynchronous reset mid-stall
    rst_n = 1'b0; #1;
    check("async_rst_ctl", ctl(), IDLE);
    check("async_rst_outstanding", 32'(outstanding), 0);
    check("async_rst_err", 32'(err), 0);
    step();
    rst_n = 1'b1; #1;
    check("post_rst_no_pending", ctl(), IDLE);
    id_we = 0;
    wb_valid = 1; wb_rd = 9; step();
    wb_valid = 0; #1;
    check("underflow_err", 32'(err), 1);
    check("underflow_count", 32'(outstanding), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Stall/flush controller that pairs with the EX-stage forwarding mux.
- Forwarding resolves ordinary RAW hazards. This block detects the hazards forwarding cannot cover and freezes or bubbles the pipeline until they clear:
  - load-use in EX;
  - variable-latency loads still outstanding in the data-memory path (tracked by a register scoreboard);
  - WAW against a pending load.
- It also generates branch flushes. It sits in the top-level core beside the forwarding unit, driving the IF/ID and ID/EX pipeline-register enables and clears.

Parameters:
- MAX_OUTSTANDING, 2, maximum loads in flight between request issue and writeback (1..7).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding-load counter (derived; do not override).

Ports:
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_rs1  in  5  source reg 1 of instruction in ID
- i_id_rs2  in  5  source reg 2 of instruction in ID
- i_id_rs1_used  in  1  ID instruction reads rs1
- i_id_rs2_used  in  1  ID instruction reads rs2
- i_id_rd  in  5  dest reg of ID instruction
- i_id_r_we  in  1  ID instruction writes rd
- i_id_mem_read  in  1  ID instruction is a load
- i_ex_rd  in  5  dest reg of instruction in EX
- i_ex_mem_read  in  1  EX instruction is a load
- i_ex_branch_taken  in  1  EX resolved a taken branch/jump
- i_mem_req_fire  in  1  load request accepted by data memory this cycle
- i_mem_req_rd  in  5  dest reg of that load
- i_wb_load_valid  in  1  load data written back this cycle
- i_wb_load_rd  in  5  dest reg of returning load
- o_stall_if  out  1  hold PC
- o_stall_id  out  1  hold IF/ID register
- o_bubble_ex  out  1  insert NOP into ID/EX
- o_flush_if_id  out  1  clear IF/ID
- o_flush_id_ex  out  1  clear ID/EX
- o_outstanding  out  CNT_W  loads in flight
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (async on i_rst_n low):
  - scoreboard pending[31:0]=0, counter=0, o_err=0.
  - All outputs read 0 while reset is asserted.
  - Reset mid-operation discards all in-flight tracking; a later stray i_wb_load_valid is handled as an underflow (see below).
- Registered state: pending[31:0], outstanding counter, o_err. Stall/flush outputs are combinational from inputs plus registered state; zero-cycle latency.
- rs hit = (rs1_used && rs1==R) || (rs2_used && rs2==R). x0 never matches.
- Load-use: i_ex_mem_read && i_ex_rd!=0 && rs hit on i_ex_rd -> stall.
- Scoreboard RAW: pending[rs] set for a used rs -> stall. Exception: the bit is being cleared this cycle by i_wb_load_valid with the same rd; the register file is write-through, so there is no stall.
- WAW: i_id_r_we && i_id_rd!=0 && pending[i_id_rd] and not clearing this cycle -> stall.
- Capacity: i_id_mem_read && counter==MAX_OUTSTANDING && !i_wb_load_valid -> stall.
- Any stall condition drives o_stall_if=o_stall_id=o_bubble_ex=1.
- Branch: i_ex_branch_taken drives o_flush_if_id=o_flush_id_ex=1. Flush has priority: all stall outputs are forced to 0 in that cycle.
- Scoreboard update each edge:
  - i_wb_load_valid clears pending[i_wb_load_rd].
  - i_mem_req_fire && i_mem_req_rd!=0 sets pending[i_mem_req_rd].
  - Same rd set and cleared in one cycle: set wins.
  - Bit 0 always reads 0.
- Counter:
  - +1 on req_fire, -1 on wb_load_valid; both together -> unchanged.
  - Loads to x0 still count.
- Errors:
  - req_fire at full: counter saturates at MAX, o_err=1.
  - wb_load_valid at 0: counter stays 0, o_err=1.
  - o_err clears only on reset.
- o_outstanding = counter (registered).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds output o_stall_cycles [31:0]. It increments every cycle o_stall_id=1, wraps at 2^32, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- EX load rd=5 (i_ex_mem_read=1), ID rs1=5 used -> o_stall_if/o_stall_id/o_bubble_ex=1 same cycle. Same with rs1=5 unused, or rd=0 -> all 0.
- req_fire rd=7; next cycle ID rs2=7 used -> stall held each cycle until i_wb_load_valid rd=7. In that cycle stall=0, and pending[7]=0 after the edge.
- MAX_OUTSTANDING=2: two req_fire (rd=3, rd=4), ID load -> stall, o_outstanding=2. A third req_fire -> o_err=1, counter stays 2.
- Stall condition active plus i_ex_branch_taken=1 -> o_flush_if_id=o_flush_id_ex=1, stall outputs 0.
- Same cycle req_fire rd=9 and wb_load_valid rd=9 with counter=1 -> pending[9]=1, counter stays 1. ID i_id_r_we rd=9 next cycle -> WAW stall.
- Assert i_rst_n low mid-stall with pending bits set -> outputs 0 immediately, pending/counter/o_err cleared. A subsequent wb_load_valid -> o_err=1.
